// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared writeback-select and load-funct3 constants
package rv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Writeback mux select encodings
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // A write to x0 never reaches the register file
   function automatic logic rd_writes(input logic [4:0] rd, input logic reg_we);
      return reg_we && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - combinational byte/halfword select and sign/zero extend for loads
module load_ext
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the loaded word
   always_comb begin
      byte_sel = data[7:0];
      case (addr_lo)
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         2'd3:    byte_sel = data[31:24];
         default: byte_sel = data[7:0];
      endcase
      half_sel = addr_lo[1] ? data[31:16] : data[15:0];
   end

   // Extend the selected field according to the load type; words pass through
   always_comb begin
      result = data;
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   result = data;
         default: result = data;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with skid buffer; LOAD_EXT_EN enables load extension
module mem_wb_stage
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_res,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] pc4,
   input  logic [XLEN-1:0] imm,
   input  logic [1:0]      wb_sel,
   input  logic [4:0]      rd,
   input  logic            reg_we,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      addr_lo,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [XLEN-1:0] out_c,
   output logic [XLEN-1:0] out_d,
   output logic [1:0]      out_sel,
   output logic [4:0]      out_rd,
   output logic            out_we
);

   // Value captured into the out_b slot and the effective write enable
   logic [XLEN-1:0] cap_b;
   logic            cap_we;

`ifdef LOAD_EXT_EN
   logic [XLEN-1:0] ext_data;

   load_ext #(
      .XLEN(XLEN)
   ) u_load_ext (
      .data    (mem_rdata),
      .funct3  (ld_funct3),
      .addr_lo (addr_lo),
      .result  (ext_data)
   );

   // Only memory-sourced writebacks are extended; other paths keep the raw word
   assign cap_b = (wb_sel == WB_SEL_MEM) ? ext_data : mem_rdata;
`else
   logic unused_load_bits;

   assign unused_load_bits = ^{ld_funct3, addr_lo};
   assign cap_b            = mem_rdata;
`endif

   assign cap_we = rd_writes(rd, reg_we);

   // Main entry: drives the outputs
   logic            main_v;
   logic [XLEN-1:0] main_a, main_b, main_c, main_d;
   logic [1:0]      main_sel;
   logic [4:0]      main_rd;
   logic            main_we;

   // Skid entry: holds the one instruction accepted while main is stalled
   logic            skid_v;
   logic [XLEN-1:0] skid_a, skid_b, skid_c, skid_d;
   logic [1:0]      skid_sel;
   logic [4:0]      skid_rd;
   logic            skid_we;

   logic            in_ready_q;

   // Next-state control
   logic            accept;
   logic            main_load_in;
   logic            main_load_skid;
   logic            skid_load;
   logic            main_v_d;
   logic            skid_v_d;

   // Decide where an accepted instruction lands and how the entries advance.
   // in_ready_q mirrors "skid empty", so an accept never coincides with a full skid.
   always_comb begin
      accept         = in_valid && in_ready_q && !flush;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      main_v_d       = main_v;
      skid_v_d       = skid_v;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v && out_ready) begin
         main_load_skid = 1'b1;
         main_v_d       = 1'b1;
         skid_v_d       = 1'b0;
      end else if (accept && (!main_v || out_ready)) begin
         main_load_in = 1'b1;
         main_v_d     = 1'b1;
      end else if (accept) begin
         skid_load = 1'b1;
         skid_v_d  = 1'b1;
      end else if (main_v && out_ready) begin
         main_v_d = 1'b0;
      end
   end

   // Valid bits and the registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v     <= 1'b0;
         skid_v     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         main_v     <= main_v_d;
         skid_v     <= skid_v_d;
         in_ready_q <= !skid_v_d;
      end
   end

   // Main payload: refilled from skid first to keep order, else from the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_a   <= '0;
         main_b   <= '0;
         main_c   <= '0;
         main_d   <= '0;
         main_sel <= WB_SEL_ALU;
         main_rd  <= 5'd0;
         main_we  <= 1'b0;
      end else if (main_load_skid) begin
         main_a   <= skid_a;
         main_b   <= skid_b;
         main_c   <= skid_c;
         main_d   <= skid_d;
         main_sel <= skid_sel;
         main_rd  <= skid_rd;
         main_we  <= skid_we;
      end else if (main_load_in) begin
         main_a   <= alu_res;
         main_b   <= cap_b;
         main_c   <= pc4;
         main_d   <= imm;
         main_sel <= wb_sel;
         main_rd  <= rd;
         main_we  <= cap_we;
      end
   end

   // Skid payload: captured only when main is occupied and stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_a   <= '0;
         skid_b   <= '0;
         skid_c   <= '0;
         skid_d   <= '0;
         skid_sel <= WB_SEL_ALU;
         skid_rd  <= 5'd0;
         skid_we  <= 1'b0;
      end else if (skid_load) begin
         skid_a   <= alu_res;
         skid_b   <= cap_b;
         skid_c   <= pc4;
         skid_d   <= imm;
         skid_sel <= wb_sel;
         skid_rd  <= rd;
         skid_we  <= cap_we;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_v;
   assign out_a     = main_a;
   assign out_b     = main_b;
   assign out_c     = main_c;
   assign out_d     = main_d;
   assign out_sel   = main_sel;
   assign out_rd    = main_rd;
   assign out_we    = main_we && main_v;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

`ifdef LOAD_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] alu_res = '0, mem_rdata = '0, pc4 = '0, imm = '0;
   logic [1:0]  wb_sel = '0;
   logic [4:0]  rd = '0;
   logic        reg_we = 1'b0;
   logic [2:0]  ld_funct3 = '0;
   logic [1:0]  addr_lo = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_a, out_b, out_c, out_d;
   logic [1:0]  out_sel;
   logic [4:0]  out_rd;
   logic        out_we;

   mem_wb_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_res(alu_res), .mem_rdata(mem_rdata), .pc4(pc4), .imm(imm),
      .wb_sel(wb_sel), .rd(rd), .reg_we(reg_we), .ld_funct3(ld_funct3),
      .addr_lo(addr_lo), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
      .out_sel(out_sel), .out_rd(out_rd), .out_we(out_we)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a, b, c, d;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every output handshake pops the oldest expected entry
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && !flush && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual out_a=%h required no output", out_a);
         end else begin
            e = sb_q.pop_front();
            check("sb_a", out_a, e.a);
            check("sb_b", out_b, e.b);
            check("sb_c", out_c, e.c);
            check("sb_d", out_d, e.d);
            check("sb_sel", {30'd0, out_sel}, {30'd0, e.sel});
            check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("sb_we", {31'd0, out_we}, {31'd0, e.we});
         end
      end
   end

   // Present one instruction, wait (bounded) for in_ready, push expectation on accept
   task automatic send(input logic [31:0] a, input logic [31:0] m, input logic [1:0] sel,
                       input logic [4:0] r, input logic we, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] eb);
      exp_t e;
      int   n;
      in_valid  = 1'b1;
      alu_res   = a;
      mem_rdata = m;
      pc4       = a + 32'h4;
      imm       = ~a;
      wb_sel    = sel;
      rd        = r;
      reg_we    = we;
      ld_funct3 = f3;
      addr_lo   = lo;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual in_ready=0 required 1");
      end else begin
         e.a   = a;
         e.b   = eb;
         e.c   = a + 32'h4;
         e.d   = ~a;
         e.sel = sel;
         e.rd  = r;
         e.we  = we && (r != 5'd0);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_we", {31'd0, out_we}, 32'd0);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_sel", {30'd0, out_sel}, 32'd0);
      check("rst_out_rd", {27'd0, out_rd}, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Single LB, byte 3, one-cycle latency
      send(32'h11, 32'h80FF_1234, 2'b01, 5'd3, 1'b1, 3'b000, 2'd3, EXT ? 32'hFFFF_FF80 : 32'h80FF_1234);
      check("lb_valid", {31'd0, out_valid}, 32'd1);
      check("lb_out_b", out_b, EXT ? 32'hFFFF_FF80 : 32'h80FF_1234);

      // Halfword and byte variants, back to back
      send(32'h21, 32'h8001_0000, 2'b01, 5'd4, 1'b1, 3'b101, 2'd2, EXT ? 32'h0000_8001 : 32'h8001_0000);
      send(32'h22, 32'h8001_0000, 2'b01, 5'd5, 1'b1, 3'b001, 2'd2, EXT ? 32'hFFFF_8001 : 32'h8001_0000);
      send(32'h23, 32'h0000_F100, 2'b01, 5'd6, 1'b1, 3'b100, 2'd1, EXT ? 32'h0000_00F1 : 32'h0000_F100);
      send(32'h24, 32'h1234_5678, 2'b01, 5'd6, 1'b1, 3'b000, 2'd0, EXT ? 32'h0000_0078 : 32'h1234_5678);
      send(32'h25, 32'hDEAD_BEEF, 2'b01, 5'd8, 1'b1, 3'b010, 2'd1, 32'hDEAD_BEEF);
      send(32'h26, 32'hDEAD_BEEF, 2'b01, 5'd8, 1'b1, 3'b011, 2'd3, 32'hDEAD_BEEF);
      send(32'h27, 32'h80FF_1234, 2'b00, 5'd9, 1'b1, 3'b000, 2'd3, 32'h80FF_1234);
      send(32'h28, 32'h8001_0000, 2'b10, 5'd9, 1'b0, 3'b001, 2'd2, 32'h8001_0000);

      // x0 destination suppresses the write
      send(32'h5, 32'h0, 2'b00, 5'd0, 1'b1, 3'b010, 2'd0, 32'h0);
      check("rd0_we", {31'd0, out_we}, 32'd0);
      send(32'h5, 32'h0, 2'b00, 5'd7, 1'b1, 3'b010, 2'd0, 32'h0);
      check("rd7_we", {31'd0, out_we}, 32'd1);
      check("rd7_a", out_a, 32'h5);
      check("rd7_sel", {30'd0, out_sel}, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // Stall: two held, ready drops, third waits, then released in order
      out_ready = 1'b0;
      send(32'h31, 32'h0, 2'b11, 5'd10, 1'b1, 3'b010, 2'd0, 32'h0);
      send(32'h32, 32'h0, 2'b11, 5'd11, 1'b1, 3'b010, 2'd0, 32'h0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_a0", out_a, 32'h31);
      repeat (3) @(posedge clk);
      #1;
      check("stall_a1", out_a, 32'h31);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      fork
         send(32'h33, 32'h0, 2'b10, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0);
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("drain1_empty", sb_q.size(), 32'd0);
      check("drain1_in_ready", {31'd0, in_ready}, 32'd1);

      // Flush with both entries full and a concurrent input
      out_ready = 1'b0;
      send(32'h41, 32'h0, 2'b00, 5'd13, 1'b1, 3'b010, 2'd0, 32'h0);
      send(32'h42, 32'h0, 2'b00, 5'd14, 1'b1, 3'b010, 2'd0, 32'h0);
      in_valid = 1'b1;
      alu_res  = 32'h43;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      check("flush_we", {31'd0, out_we}, 32'd0);
      out_ready = 1'b1;
      send(32'h44, 32'h0, 2'b00, 5'd15, 1'b1, 3'b010, 2'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      send(32'h51, 32'h0, 2'b10, 5'd16, 1'b1, 3'b010, 2'd0, 32'h0);
      send(32'h52, 32'h0, 2'b10, 5'd17, 1'b1, 3'b010, 2'd0, 32'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_we", {31'd0, out_we}, 32'd0);
      check("arst_a", out_a, 32'd0);
      check("arst_b", out_b, 32'd0);
      check("arst_c", out_c, 32'd0);
      check("arst_sel", {30'd0, out_sel}, 32'd0);
      check("arst_rd", {27'd0, out_rd}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(32'h61, 32'h0, 2'b00, 5'd18, 1'b1, 3'b010, 2'd0, 32'h0);
      check("post_rst_valid", {31'd0, out_valid}, 32'd1);
      check("post_rst_a", out_a, 32'h61);
      repeat (4) @(posedge clk);
      #1;
      check("final_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
